// File: rtl/output_display_controller_if.sv
// Load/result bundle between the output register control
// and the display controller.
interface output_display_controller_if;
  logic        load;
  logic [7:0]  bus;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  modport master (
    output load,
    output bus,
    input  busy,
    input  done,
    input  bcd
  );

  modport slave (
    input  load,
    input  bus,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/output_display_controller.sv
// Display path sequencer: serial double-dabble binary-to-BCD
// and a multiplexed 4-digit common-anode 7-segment scan.
module output_display_controller #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                              clk,
  input  logic                              clear_n,
  output_display_controller_if.slave        io,
  output logic [6:0]                        seg,
  output logic [3:0]                        an
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [6:0] SegBlank = 7'h7F;

  state_e      state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [19:0] adj;
  logic [2:0]  bit_q, bit_d;
  logic [11:0] bcd_q, bcd_d;
  logic        busy_q;
  logic        done_q;

  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_raw;
  logic [3:0]  an_raw;
  logic        wrap;
  logic        blank_h;
  logic        blank_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Add-3 correction on every BCD nibble before each shift
  assign adj = {add3(sr_q[19:16]),
                add3(sr_q[15:12]),
                add3(sr_q[11:8]),
                sr_q[7:0]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (io.load && !busy_q) begin
          sr_d    = {12'h000, io.bus};
          bit_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {adj[18:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = sr_q[19:8];
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= IDLE;
      sr_q    <= 20'h0;
      bit_q   <= 3'd0;
      bcd_q   <= 12'h000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      bcd_q   <= bcd_d;
      busy_q  <= (state_q != IDLE);
      done_q  <= (state_q == DONE);
    end
  end

  assign wrap    = (cnt_q == REFRESH_DIV - 16'd1);
  assign blank_h = (bcd_q[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);

  always_comb begin
    cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    seg_raw = SegBlank;
    an_raw  = 4'b1111;
    unique case (idx_d)
      2'd0: begin
        seg_raw = digit_seg(bcd_q[3:0]);
        an_raw  = 4'b1110;
      end
      2'd1: begin
        seg_raw = blank_t ? SegBlank : digit_seg(bcd_q[7:4]);
        an_raw  = 4'b1101;
      end
      2'd2: begin
        seg_raw = blank_h ? SegBlank : digit_seg(bcd_q[11:8]);
        an_raw  = 4'b1011;
      end
      default: begin
        seg_raw = SegBlank;
        an_raw  = 4'b0111;
      end
    endcase
    seg_d = ACTIVE_LOW ? seg_raw : ~seg_raw;
    an_d  = ACTIVE_LOW ? an_raw : ~an_raw;
  end

  // Outputs follow the next scan index so they move with it
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_q <= 16'd0;
      idx_q <= 2'd0;
      seg_q <= ACTIVE_LOW ? SegBlank : ~SegBlank;
      an_q  <= ACTIVE_LOW ? 4'b1111 : 4'b0000;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bcd  = bcd_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_output_display_controller.sv
// Scoreboard bench for output_display_controller
// with REFRESH_DIV=4 and active-low outputs.
module tb_output_display_controller;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [6:0] seg;
  logic [3:0] an;

  output_display_controller_if ifc();

  output_display_controller #(
    .REFRESH_DIV(16'd4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .io     (ifc),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clear_n === 1'b1 && ifc.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done bcd %h expected none", ifc.bcd);
      end else begin
        chk("bcd_result", {20'h0, ifc.bcd}, {20'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    ifc.load = 1'b1;
    ifc.bus  = v;
    @(negedge clk);
    ifc.load = 1'b0;
    ifc.bus  = 8'h00;
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] e);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    exp_q.push_back(e);
    do_load(v);
    repeat (14) begin
      if (ifc.busy === 1'b1) n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 9);
    chk("done_pulses", done_cnt - d0, 1);
    chk("bcd_hold", {20'h0, ifc.bcd}, {20'h0, e});
  endtask

  task automatic check_display(input logic [6:0] s0,
                               input logic [6:0] s1,
                               input logic [6:0] s2);
    repeat (16) begin
      @(negedge clk);
      case (an)
        4'b1110: chk("seg_ones", {25'h0, seg}, {25'h0, s0});
        4'b1101: chk("seg_tens", {25'h0, seg}, {25'h0, s1});
        4'b1011: chk("seg_hund", {25'h0, seg}, {25'h0, s2});
        4'b0111: chk("seg_unused", {25'h0, seg}, 32'h7F);
        default: chk("an_onehot", {28'h0, an}, 32'hE);
      endcase
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] a);
    case (a)
      4'b1110: return 4'b1101;
      4'b1101: return 4'b1011;
      4'b1011: return 4'b0111;
      default: return 4'b1110;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int run;
    int ntrans;
    logic [3:0] prev;

    clear_n  = 1'b0;
    ifc.load = 1'b0;
    ifc.bus  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'h0, ifc.busy}, 0);
    chk("rst_done", {31'h0, ifc.done}, 0);
    chk("rst_bcd", {20'h0, ifc.bcd}, 0);
    chk("rst_seg", {25'h0, seg}, 32'h7F);
    chk("rst_an", {28'h0, an}, 32'hF);
    clear_n = 1'b1;

    convert(8'd255, 12'h255);
    check_display(7'h12, 7'h12, 7'h24);

    convert(8'd0, 12'h000);
    check_display(7'h40, 7'h7F, 7'h7F);

    convert(8'd105, 12'h105);
    check_display(7'h12, 7'h40, 7'h79);

    // Second load lands while busy and must be dropped
    d0 = done_cnt;
    exp_q.push_back(12'h042);
    @(negedge clk);
    ifc.load = 1'b1;
    ifc.bus  = 8'd42;
    @(negedge clk);
    ifc.load = 1'b0;
    @(negedge clk);
    ifc.load = 1'b1;
    ifc.bus  = 8'd99;
    @(negedge clk);
    ifc.load = 1'b0;
    repeat (25) @(negedge clk);
    chk("ignored_done", done_cnt - d0, 1);
    chk("ignored_bcd", {20'h0, ifc.bcd}, 32'h042);

    // Reset aborts a conversion in flight
    d0 = done_cnt;
    do_load(8'd200);
    repeat (3) @(negedge clk);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    chk("abort_busy", {31'h0, ifc.busy}, 0);
    chk("abort_bcd", {20'h0, ifc.bcd}, 0);
    repeat (15) @(negedge clk);
    chk("abort_nodone", done_cnt - d0, 0);
    chk("abort_bcd2", {20'h0, ifc.bcd}, 0);

    convert(8'd7, 12'h007);
    check_display(7'h78, 7'h7F, 7'h7F);

    prev   = an;
    run    = 1;
    ntrans = 0;
    repeat (64) begin
      @(negedge clk);
      if (an === prev) begin
        run++;
      end else begin
        chk("an_order", {28'h0, an}, {28'h0, nxt(prev)});
        if (ntrans > 0) chk("an_hold", run, 4);
        ntrans++;
        run  = 1;
        prev = an;
      end
    end
    chk("an_transitions", ntrans, 16);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
